// File: rtl/param_down_counter.sv
// rtl/param_down_counter.sv - loadable down-counter with run-time wrap/saturate underflow handling
module param_down_counter #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   bw;
    logic             underflow;

    // Ripple-borrow chain; the MSB borrow-out is the underflow flag.
    assign bw[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fs
        assign diff[i]  = q_q[i] ^ step[i] ^ bw[i];
        assign bw[i+1]  = (~q_q[i] & step[i]) | (~(q_q[i] ^ step[i]) & bw[i]);
    end
    assign underflow = bw[WIDTH];

    always_comb begin
        q_d      = q_q;
        borrow_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (underflow) begin
                borrow_d = 1'b1;
                q_d      = sat ? '0 : diff;
            end else begin
                q_d = diff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= RST_VAL;
            borrow_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = q_q;
    assign borrow = borrow_q;
    assign zero   = (q_q == '0);

endmodule

// File: tb/tb_param_down_counter.sv
// tb/tb_param_down_counter.sv - scoreboard bench for param_down_counter with random and directed stimulus
module tb_param_down_counter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] step;
    logic         sat;
    logic [W-1:0] q;
    logic         zero;
    logic         borrow;

    param_down_counter #(.WIDTH(W), .RST_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .step(step), .sat(sat), .q(q), .zero(zero), .borrow(borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         b;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model = 0;
    bit   sweep_on = 1'b0;
    int   sweep_borrows = 0;

    // Monitor: one registered result per edge; compared against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (q !== e.q || borrow !== e.b || zero !== (e.q == 0)) begin
                failures++;
                $display("FAIL %s: got q=%h borrow=%b zero=%b, want q=%h borrow=%b zero=%b",
                         e.tag, q, borrow, zero, e.q, e.b, (e.q == 0));
            end
            if (sweep_on && borrow === 1'b1) sweep_borrows++;
        end
    end

    task automatic drive(input bit ld, input logic [W-1:0] lv, input bit e,
                         input logic [W-1:0] st, input bit s, input string tag);
        exp_t x;
        int   d;
        @(negedge clk);
        load = ld; load_val = lv; en = e; step = st; sat = s;
        x.b = 1'b0;
        if (ld) begin
            model = int'(lv);
        end else if (e) begin
            d = model - int'(st);
            if (d < 0) begin
                x.b   = 1'b1;
                model = s ? 0 : d + (1 << W);
            end else begin
                model = d;
            end
        end
        x.q   = model[W-1:0];
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic direct_check(input string tag, input logic [W-1:0] wq, input bit wb);
        checks++;
        if (q !== wq || borrow !== wb || zero !== (wq == 0)) begin
            failures++;
            $display("FAIL %s: got q=%h borrow=%b zero=%b, want q=%h borrow=%b zero=%b",
                     tag, q, borrow, zero, wq, wb, (wq == 0));
        end
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; load = 0; load_val = '0; en = 0; step = '0; sat = 0;
        repeat (2) @(negedge clk);
        direct_check("reset_state", 16'h0000, 1'b0);
        rst = 1'b0;
        model = 0;

        // Mid-clock asynchronous reset from a non-zero count with a borrow pending.
        drive(1, 16'h0001, 0, 0, 0, "pre_reset_load");
        drive(0, 0, 1, 16'h0002, 0, "pre_reset_wrap");
        drive(1, 16'h1234, 0, 0, 0, "pre_reset_1234");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        direct_check("async_reset", 16'h0000, 1'b0);
        model = 0;
        @(negedge clk);
        load = 0; en = 1; step = 16'h0003;
        x.q = 16'h0000; x.b = 1'b0; x.tag = "reset_held";
        exp_q.push_back(x);
        @(negedge clk);
        rst = 1'b0;
        en = 0;

        drive(1, 16'h00FF, 1, 16'h0005, 0, "load_priority");
        for (int i = 0; i < 15; i++) drive(0, 0, 1, 16'h0010, 0, "step_0x10");
        drive(0, 0, 1, 16'h000F, 0, "exact_reach");
        drive(0, 0, 1, 16'h0000, 0, "step_zero");
        drive(1, 16'h0002, 0, 0, 0, "load_2");
        drive(0, 0, 1, 16'h0005, 0, "wrap");
        drive(0, 0, 0, 16'h0005, 0, "hold_after_wrap");
        drive(1, 16'h0003, 0, 0, 1, "load_3");
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'h0010, 1, "saturate");
        drive(0, 0, 1, 16'h0001, 0, "wrap_from_zero");

        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] st;
            case ($urandom_range(0, 3))
                0:       st = '0;
                1:       st = model[W-1:0];
                2:       st = W'($urandom);
                default: st = W'($urandom_range(1, 8));
            endcase
            drive($urandom_range(0, 15) == 0, W'($urandom), $urandom_range(0, 3) != 0,
                  st, $urandom_range(0, 1) == 1, "random");
        end

        drive(1, 16'hFFFF, 0, 0, 0, "sweep_load");
        @(posedge clk);
        #2;
        sweep_on = 1'b1;
        for (int i = 0; i < 65536; i++) drive(0, 0, 1, 16'h0001, 0, "sweep");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        checks++;
        if (sweep_borrows != 1) begin
            failures++;
            $display("FAIL sweep_borrow_count: got %0d, want 1", sweep_borrows);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
